// File: rtl/reservation_station_pkg.sv
// Shared core package: machine-wide widths and the canonical reservation
// station entry layout used by the decode, rename and dispatch stages.
//
// Contents
//   PREG_W    physical register tag width (128 physical registers)
//   RS_DEPTH  default reservation station depth
//   OPCODE_W  opcode field width
//   INSTR_W   raw instruction width
//   rs_entry_t one reservation station entry
package reservation_station_pkg;

    localparam int PREG_W   = 7;
    localparam int RS_DEPTH = 8;
    localparam int OPCODE_W = 7;
    localparam int INSTR_W  = 32;

    typedef struct packed {
        logic                valid;
        logic [OPCODE_W-1:0] opcode;
        logic [PREG_W-1:0]   ps1;
        logic                rdy1;
        logic [PREG_W-1:0]   ps2;
        logic                rdy2;
        logic [PREG_W-1:0]   pd;
        logic [INSTR_W-1:0]  instr;
    } rs_entry_t;

endpackage

// File: rtl/reservation_station_pick.sv
// rs_pick_lowest: parameterised priority encoder; finds the lowest set bit
// of a request vector and reports it both one-hot and as a binary index.
//
// Ports
//   req_i    [N-1:0]     request vector, bit 0 has highest priority
//   any_o                at least one request bit set
//   onehot_o [N-1:0]     one-hot of the winning bit (all zero if none)
//   idx_o    [IDX_W-1:0] index of the winning bit (zero if none)
module rs_pick_lowest #(
    parameter int N     = 8,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    output logic             any_o,
    output logic [N-1:0]     onehot_o,
    output logic [IDX_W-1:0] idx_o
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        any_o    = 1'b0;
        onehot_o = '0;
        idx_o    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                any_o       = 1'b1;
                onehot_o    = '0;
                onehot_o[i] = 1'b1;
                idx_o       = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// reservation_station: out-of-order issue queue. Holds renamed instructions
// until both source operands are ready, then issues the lowest-index ready
// entry. Dispatch picks the lowest-index free slot.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   flush                       discard all entries
//   in_valid / in_ready         dispatch handshake (in_ready = any slot free)
//   in_opcode, in_instr         passed-through payload
//   in_ps1, in_ps2, in_pd       source/destination physical tags
//   in_ps1_rdy, in_ps2_rdy      operand already available at dispatch
//   wb_valid, wb_pd             wakeup broadcast of a completing tag
//   iss_valid / iss_ready       issue handshake
//   iss_opcode, iss_ps1, iss_ps2, iss_pd, iss_instr  selected entry fields
//   occupancy                   number of valid entries
module reservation_station
    import reservation_station_pkg::OPCODE_W;
    import reservation_station_pkg::INSTR_W;
#(
    parameter int RS_DEPTH = reservation_station_pkg::RS_DEPTH,
    parameter int PREG_W   = reservation_station_pkg::PREG_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [OPCODE_W-1:0]       in_opcode,
    input  logic [INSTR_W-1:0]        in_instr,
    input  logic [PREG_W-1:0]         in_ps1,
    input  logic [PREG_W-1:0]         in_ps2,
    input  logic [PREG_W-1:0]         in_pd,
    input  logic                      in_ps1_rdy,
    input  logic                      in_ps2_rdy,
    input  logic                      wb_valid,
    input  logic [PREG_W-1:0]         wb_pd,
    output logic                      iss_valid,
    input  logic                      iss_ready,
    output logic [OPCODE_W-1:0]       iss_opcode,
    output logic [PREG_W-1:0]         iss_ps1,
    output logic [PREG_W-1:0]         iss_ps2,
    output logic [PREG_W-1:0]         iss_pd,
    output logic [INSTR_W-1:0]        iss_instr,
    output logic [$clog2(RS_DEPTH):0] occupancy
);

    localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
    localparam int OCC_W = $clog2(RS_DEPTH) + 1;

    // Control state (reset)
    logic [RS_DEPTH-1:0] valid_q, valid_d;
    logic [RS_DEPTH-1:0] rdy1_q, rdy1_d;
    logic [RS_DEPTH-1:0] rdy2_q, rdy2_d;
    logic [OCC_W-1:0]    occ_q, occ_d;

    // Payload (no reset; only meaningful while the valid bit is set)
    logic [OPCODE_W-1:0] opcode_q [RS_DEPTH];
    logic [PREG_W-1:0]   ps1_q    [RS_DEPTH];
    logic [PREG_W-1:0]   ps2_q    [RS_DEPTH];
    logic [PREG_W-1:0]   pd_q     [RS_DEPTH];
    logic [INSTR_W-1:0]  instr_q  [RS_DEPTH];

    logic [RS_DEPTH-1:0] free_req, free_oh, rdy_req, rdy_oh;
    logic [IDX_W-1:0]    free_idx, rdy_idx;
    logic                free_any, rdy_any;
    logic                dispatch, issue;
    logic                new_rdy1, new_rdy2;

    // Both pickers look only at registered state, so a slot freed by an
    // issue this cycle is not reused until the next cycle, and in_ready /
    // iss_valid carry no combinational path from iss_ready or wakeup.
    assign free_req = ~valid_q;
    assign rdy_req  = valid_q & rdy1_q & rdy2_q;

    rs_pick_lowest #(.N(RS_DEPTH), .IDX_W(IDX_W)) u_free_pick (
        .req_i    (free_req),
        .any_o    (free_any),
        .onehot_o (free_oh),
        .idx_o    (free_idx)
    );

    rs_pick_lowest #(.N(RS_DEPTH), .IDX_W(IDX_W)) u_rdy_pick (
        .req_i    (rdy_req),
        .any_o    (rdy_any),
        .onehot_o (rdy_oh),
        .idx_o    (rdy_idx)
    );

    assign in_ready   = free_any;
    assign iss_valid  = rdy_any;
    assign iss_opcode = opcode_q[rdy_idx];
    assign iss_ps1    = ps1_q[rdy_idx];
    assign iss_ps2    = ps2_q[rdy_idx];
    assign iss_pd     = pd_q[rdy_idx];
    assign iss_instr  = instr_q[rdy_idx];
    assign occupancy  = occ_q;

    assign dispatch = in_valid & free_any & ~flush;
    assign issue    = rdy_any & iss_ready;

    // Tag 0 is the hard-wired zero register and always ready; a same-cycle
    // broadcast is bypassed so the new entry is not left waiting forever.
    assign new_rdy1 = in_ps1_rdy | (in_ps1 == '0) | (wb_valid & (wb_pd == in_ps1));
    assign new_rdy2 = in_ps2_rdy | (in_ps2 == '0) | (wb_valid & (wb_pd == in_ps2));

    always_comb begin
        valid_d = valid_q;
        rdy1_d  = rdy1_q;
        rdy2_d  = rdy2_q;
        occ_d   = occ_q;
        if (flush) begin
            valid_d = '0;
            occ_d   = '0;
        end else begin
            // Wakeup only ever sets ready bits.
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (wb_valid && valid_q[i]) begin
                    if (ps1_q[i] == wb_pd) rdy1_d[i] = 1'b1;
                    if (ps2_q[i] == wb_pd) rdy2_d[i] = 1'b1;
                end
            end
            // The dispatch slot is currently invalid, so it never collides
            // with the wakeup loop or the issuing entry.
            if (dispatch) begin
                valid_d = valid_d | free_oh;
                rdy1_d  = (rdy1_d & ~free_oh) | (free_oh & {RS_DEPTH{new_rdy1}});
                rdy2_d  = (rdy2_d & ~free_oh) | (free_oh & {RS_DEPTH{new_rdy2}});
            end
            if (issue) valid_d = valid_d & ~rdy_oh;
            occ_d = occ_q + OCC_W'(dispatch) - OCC_W'(issue);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            rdy1_q  <= '0;
            rdy2_q  <= '0;
            occ_q   <= '0;
        end else begin
            valid_q <= valid_d;
            rdy1_q  <= rdy1_d;
            rdy2_q  <= rdy2_d;
            occ_q   <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (dispatch) begin
            opcode_q[free_idx] <= in_opcode;
            ps1_q[free_idx]    <= in_ps1;
            ps2_q[free_idx]    <= in_ps2;
            pd_q[free_idx]     <= in_pd;
            instr_q[free_idx]  <= in_instr;
        end
    end

endmodule
